// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per clock with a registered carry.
// Optional flags V/Z are built only when ADDSUB_FLAGS_EN is defined.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding chunk k each cycle, carry held in c_q
// DONE  | result valid, held until out_ready
module chunked_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef ADDSUB_FLAGS_EN
    ,
    output logic             V,
    output logic             Z
`endif
);

    localparam int NCHUNK = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    if ((CHUNK < 1) ? 1'b1 : ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
        $error("chunked_addsub: CHUNK must be >= 1 and divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
`ifdef ADDSUB_FLAGS_EN
    logic             v_q, v_d;
    logic             z_q, z_d;
`endif

    logic [IW-1:0]    base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] s_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
`ifdef ADDSUB_FLAGS_EN
            v_q     <= 1'b0;
            z_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
`ifdef ADDSUB_FLAGS_EN
            v_q     <= v_d;
            z_q     <= z_d;
`endif
        end
    end

    // Chunk datapath: the slice selected by k is added with the held carry.
    always_comb begin
        base    = IW'(k_q * CHUNK);
        a_chunk = x_q[base +: CHUNK];
        b_chunk = y_q[base +: CHUNK];
        sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_q};
        s_full  = s_q;
        s_full[base +: CHUNK] = sum[CHUNK-1:0];
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        s_d     = s_q;
        cout_d  = cout_q;
`ifdef ADDSUB_FLAGS_EN
        v_d     = v_q;
        z_d     = z_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    x_d     = X;
                    y_d     = sub ? ~Y : Y;
                    c_d     = Cin ^ sub;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d = s_full;
                c_d = sum[CHUNK];
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    cout_d  = sum[CHUNK];
                    k_d     = '0;
                    state_d = DONE;
`ifdef ADDSUB_FLAGS_EN
                    // a^b^s at the MSB recovers the carry into the MSB.
                    v_d = x_q[WIDTH-1] ^ y_q[WIDTH-1] ^ s_full[WIDTH-1] ^ sum[CHUNK];
                    z_d = (s_full == '0);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign Cout      = cout_q;
`ifdef ADDSUB_FLAGS_EN
    assign V         = v_q;
    assign Z         = z_q;
`endif

endmodule
